// File: rtl/conv1d_pkg.sv
// Shared definitions for the streaming 1-D convolution block: FSM states and
// the width helpers used to size the full-precision accumulator.
package conv1d_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Full-precision width: one product plus growth for KLEN additions plus a guard bit
    function automatic int acc_width(input int data_w, input int coef_w, input int klen);
        return data_w + coef_w + $clog2(klen) + 1;
    endfunction

    function automatic int idx_width(input int klen);
        return (klen > 1) ? $clog2(klen) : 1;
    endfunction

endpackage

// File: rtl/conv1d_mac.sv
// Combinational multiply-add tree: dot product of the sample window with the
// coefficient set, sign-extended and summed at full ACC_W precision.
module conv1d_mac #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int KLEN   = 3,
    parameter int ACC_W  = 19
) (
    input  logic signed [DATA_W-1:0] win  [KLEN],
    input  logic signed [COEF_W-1:0] coef [KLEN],
    output logic signed [ACC_W-1:0]  sum
);

    logic signed [ACC_W-1:0] prod [KLEN];

    always_comb begin
        sum = '0;
        for (int j = 0; j < KLEN; j++) begin
            prod[j] = ACC_W'(win[j]) * ACC_W'(coef[j]);
            sum     = sum + prod[j];
        end
    end

endmodule

// File: rtl/conv1d_stream.sv
// Streaming full linear convolution with valid/ready handshakes and a
// zero-flush tail. Optional output clamping via `define CONV1D_SAT_EN.
module conv1d_stream
    import conv1d_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int COEF_W = 8,
    parameter  int KLEN   = 3,
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, KLEN),
    localparam int IDX_W  = idx_width(KLEN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     coef_we,
    input  logic [IDX_W-1:0]         coef_idx,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     sat_flag
);

    state_t state, state_nxt;
    logic   to_idle;

    logic signed [DATA_W-1:0] win    [KLEN];
    logic signed [DATA_W-1:0] win_sh [KLEN];
    logic signed [COEF_W-1:0] coef   [KLEN];
    logic [IDX_W-1:0]         flush_cnt;

    logic                    step_rdy, in_fire, flush_step, step, last_fire;
    logic signed [DATA_W-1:0] shift_in;
    logic signed [ACC_W-1:0]  sum_p0, res_p0;
    logic                    last_p0;

    logic signed [ACC_W-1:0] res_p1;
    logic                    vld_p1, last_p1;

`ifdef CONV1D_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction

    function automatic logic sat_hit(input logic signed [ACC_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction
`endif

    // Stage p0: handshake decode, window shift and combinational MAC
    assign step_rdy   = !vld_p1 || out_ready;
    assign in_ready   = rst_n && (state != FLUSH) && step_rdy;
    assign in_fire    = in_valid && in_ready;
    assign flush_step = (state == FLUSH) && (flush_cnt != '0) && step_rdy;
    assign step       = in_fire || flush_step;
    assign last_fire  = vld_p1 && out_ready && last_p1;
    assign shift_in   = in_fire ? in_data : '0;
    assign last_p0    = in_fire ? (in_last && (KLEN == 1)) : (flush_cnt == IDX_W'(1));

    always_comb begin
        win_sh[0] = shift_in;
        for (int i = 1; i < KLEN; i++) win_sh[i] = win[i-1];
    end

    conv1d_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .KLEN   (KLEN),
        .ACC_W  (ACC_W)
    ) u_mac (
        .win  (win_sh),
        .coef (coef),
        .sum  (sum_p0)
    );

`ifdef CONV1D_SAT_EN
    assign res_p0 = sat_clamp(sum_p0);
`else
    assign res_p0 = sum_p0;
`endif

    always_comb begin
        state_nxt = state;
        to_idle   = 1'b0;
        case (state)
            IDLE, RUN: begin
                if (in_fire) begin
                    if (!in_last)       state_nxt = RUN;
                    else if (KLEN > 1)  state_nxt = FLUSH;
                    else begin
                        state_nxt = IDLE;
                        to_idle   = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (last_fire) begin
                    state_nxt = IDLE;
                    to_idle   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            flush_cnt <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < KLEN; i++) begin
                win[i]  <= '0;
                coef[i] <= (i == 0) ? COEF_W'(1) : '0;
            end
        end else begin
            state <= state_nxt;
            if (in_fire && in_last)  flush_cnt <= IDX_W'(KLEN - 1);
            else if (flush_step)     flush_cnt <= flush_cnt - IDX_W'(1);
            if (in_fire)             busy <= 1'b1;
            else if (last_fire)      busy <= 1'b0;
            if (to_idle) begin
                for (int i = 0; i < KLEN; i++) win[i] <= '0;
            end else if (step) begin
                for (int i = 0; i < KLEN; i++) win[i] <= win_sh[i];
            end
            if (coef_we && !busy && (int'(coef_idx) < KLEN)) coef[coef_idx] <= coef_data;
        end
    end

    // Stage p1: single-entry output register, held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            res_p1  <= '0;
            last_p1 <= 1'b0;
        end else if (step) begin
            vld_p1  <= 1'b1;
            res_p1  <= res_p0;
            last_p1 <= last_p0;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

`ifdef CONV1D_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      sat_flag <= 1'b0;
        else if (step && sat_hit(sum_p0)) sat_flag <= 1'b1;
    end
`else
    assign sat_flag = 1'b0;
`endif

    assign out_valid = vld_p1;
    assign out_data  = res_p1;
    assign out_last  = last_p1;

endmodule

// File: tb/tb_conv1d_stream.sv
// Scoreboard bench for conv1d_stream: a frame-level convolution model pushes
// expected results; a negedge monitor pops and compares every output transfer.
module tb_conv1d_stream;

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int KLEN   = 3;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(KLEN) + 1;
    localparam int IDX_W  = 2;

    logic                     clk;
    logic                     rst_n;
    logic                     coef_we;
    logic [IDX_W-1:0]         coef_idx;
    logic signed [COEF_W-1:0] coef_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_last;
    logic                     busy;
    logic                     sat_flag;

    conv1d_stream #(.DATA_W(DATA_W), .COEF_W(COEF_W), .KLEN(KLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .coef_we   (coef_we),
        .coef_idx  (coef_idx),
        .coef_data (coef_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .sat_flag  (sat_flag)
    );

    typedef struct {
        longint d;
        bit     l;
    } exp_t;

    exp_t   q[$];
    exp_t   mon_e;
    int     n_tests = 0;
    int     n_fail  = 0;
    int     hmod [KLEN];
    bit     rnd_mode = 0;
    bit     hold_v = 0;
    longint hold_d;
    bit     hold_l;
    int     fr[$];

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint model_out(input longint v);
`ifdef CONV1D_SAT_EN
        if (v > 127)  return 127;
        if (v < -128) return -128;
`endif
        return v;
    endfunction

    // Reference: y[n] = sum_j h[j]*x[n-j] over n = 0 .. L+KLEN-2
    task automatic push_frame(input int x[$]);
        int L = x.size();
        for (int n = 0; n < L + KLEN - 1; n++) begin
            longint acc = 0;
            exp_t e;
            for (int j = 0; j < KLEN; j++)
                if (n - j >= 0 && n - j < L) acc += longint'(hmod[j]) * longint'(x[n-j]);
            e.d = model_out(acc);
            e.l = (n == L + KLEN - 2);
            q.push_back(e);
        end
    endtask

    task automatic put(input int d, input bit last);
        bit ok = 0;
        in_valid = 1;
        in_data  = DATA_W'(d);
        in_last  = last;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 0;
        in_last  = 0;
        if (!ok) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic send_frame(input int x[$]);
        push_frame(x);
        for (int i = 0; i < x.size(); i++) put(x[i], i == x.size() - 1);
    endtask

    task automatic write_coef(input int idx, input int val, input bit accept);
        coef_we   = 1;
        coef_idx  = IDX_W'(idx);
        coef_data = COEF_W'(val);
        @(posedge clk); #1;
        coef_we = 0;
        if (accept) hmod[idx] = val;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        chk("drain", ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic set_identity();
        for (int j = 0; j < KLEN; j++) hmod[j] = (j == 0) ? 1 : 0;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (out_valid) begin
            if (hold_v) begin
                chk("stall_data", longint'(out_data), hold_d);
                chk("stall_last", out_last, hold_l);
            end
            if (out_ready) begin
                hold_v = 0;
                if (q.size() == 0) begin
                    chk("unexpected_output", longint'(out_data), -999999);
                end else begin
                    mon_e = q.pop_front();
                    chk("out_data", longint'(out_data), mon_e.d);
                    chk("out_last", out_last, mon_e.l);
                end
            end else begin
                hold_v = 1;
                hold_d = longint'(out_data);
                hold_l = out_last;
            end
        end else begin
            hold_v = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0, expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; coef_we = 0; coef_idx = '0; coef_data = '0;
        in_valid = 0; in_data = '0; in_last = 0; out_ready = 1;
        set_identity();
        repeat (2) @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sat_flag", sat_flag, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        // Identity kernel straight out of reset
        fr = '{1, 2, 3};
        send_frame(fr);
        drain();

        // Moving sum, then the same frame under random backpressure
        for (int j = 0; j < KLEN; j++) write_coef(j, 1, 1);
        fr = '{1, 0, 1, 1};
        send_frame(fr);
        drain();
        rnd_mode = 1;
        send_frame(fr);
        drain();
        rnd_mode = 0;

        // Extreme negative values
        for (int j = 0; j < KLEN; j++) write_coef(j, -128, 1);
        fr = '{-128, -128, -128};
        send_frame(fr);
        drain();
`ifdef CONV1D_SAT_EN
        chk("sat_flag_set", sat_flag, 1);
`else
        chk("sat_flag_tied", sat_flag, 0);
`endif

        // Coefficient write during a frame must be ignored
        for (int j = 0; j < KLEN; j++) write_coef(j, 1, 1);
        fr = '{1, 2};
        push_frame(fr);
        put(1, 0);
        chk("busy_mid_frame", busy, 1);
        write_coef(0, 50, 0);
        put(2, 1);
        drain();

        // Back-to-back frames must not leak into each other
        fr = '{1};
        send_frame(fr);
        fr = '{2};
        send_frame(fr);
        drain();

        // Mid-frame reset
        fr = '{3, 4, 6, 7};
        begin
            exp_t e;
            e.l = 0;
            e.d = 3; q.push_back(e);
            e.d = 7; q.push_back(e);
        end
        put(3, 0);
        put(4, 0);
        repeat (3) @(posedge clk); #1;
        chk("partial_drained", q.size(), 0);
        @(negedge clk) rst_n = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", longint'(out_data), 0);
        chk("midrst_out_last", out_last, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_sat_flag", sat_flag, 0);
        set_identity();
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        for (int j = 0; j < KLEN; j++) write_coef(j, 1, 1);
        fr = '{5};
        send_frame(fr);
        drain();

        // Randomized frames and kernels under random backpressure
        rnd_mode = 1;
        for (int f = 0; f < 8; f++) begin
            for (int j = 0; j < KLEN; j++) write_coef(j, int'($urandom_range(0, 255)) - 128, 1);
            fr.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++)
                fr.push_back(int'($urandom_range(0, 255)) - 128);
            send_frame(fr);
            drain();
        end
        rnd_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
